// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite image memory scheduler.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } sched_state_t;

    localparam int unsigned READ_LATENCY      = 3;
    localparam int unsigned SPRITE_WIDTH      = 256;
    localparam int unsigned SPRITE_HEIGHT     = 256;
    localparam int unsigned SPRITE_PIXEL_BITS = 2;
    localparam int unsigned SPRITE_FIFO_DEPTH = 16;

endpackage

// File: rtl/sprite_mem_scheduler_if.sv
// Loader handshake and image BRAM port bundle of the sprite memory scheduler.
interface sprite_mem_scheduler_if import sprite_pkg::*; #(
    parameter int unsigned PIXEL_BITS = SPRITE_PIXEL_BITS,
    parameter int unsigned ADDR_W     = $clog2(SPRITE_WIDTH * SPRITE_HEIGHT)
);
    logic                  load_start_in;
    logic                  wr_valid_in;
    logic [PIXEL_BITS-1:0] wr_data_in;
    logic                  wr_ready_out;
    logic                  loading_out;
    logic                  load_done_out;
    logic [ADDR_W-1:0]     mem_addr_out;
    logic [PIXEL_BITS-1:0] mem_din_out;
    logic                  mem_we_out;

    modport slave (
        input  load_start_in, wr_valid_in, wr_data_in,
        output wr_ready_out, loading_out, load_done_out,
        output mem_addr_out, mem_din_out, mem_we_out
    );

    modport master (
        output load_start_in, wr_valid_in, wr_data_in,
        input  wr_ready_out, loading_out, load_done_out,
        input  mem_addr_out, mem_din_out, mem_we_out
    );
endinterface

// File: rtl/sprite_wr_fifo.sv
// Loader pixel buffer: synchronous first-word-fall-through FIFO with flush.
module sprite_wr_fifo import sprite_pkg::*; #(
    parameter int unsigned DEPTH = SPRITE_FIFO_DEPTH,
    parameter int unsigned WIDTH = SPRITE_PIXEL_BITS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_mem_scheduler.sv
// Arbitrates the single sprite BRAM port: display reads always win inside the
// sprite window, buffered loader pixels are written on the remaining cycles.
module sprite_mem_scheduler import sprite_pkg::*; #(
    parameter int unsigned WIDTH      = SPRITE_WIDTH,
    parameter int unsigned HEIGHT     = SPRITE_HEIGHT,
    parameter int unsigned PIXEL_BITS = SPRITE_PIXEL_BITS,
    parameter int unsigned FIFO_DEPTH = SPRITE_FIFO_DEPTH
) (
    input  logic                         pixel_clk_in,
    input  logic                         rst_in,
    input  logic [10:0]                  x_in,
    input  logic [9:0]                   y_in,
    input  logic [10:0]                  hcount_in,
    input  logic [9:0]                   vcount_in,
    sprite_mem_scheduler_if.slave        bus,
    output logic                         in_sprite_out
);
    localparam int unsigned TOTAL  = WIDTH * HEIGHT;
    localparam int unsigned ADDR_W = $clog2(TOTAL);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    sched_state_t            r_state;
    sched_state_t            w_state_nxt;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [CNT_W-1:0]        r_accept_cnt;
    logic [READ_LATENCY-1:0] r_hit_pipe;
    logic                    r_load_done;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [PIXEL_BITS-1:0]   r_mem_din;
    logic                    r_mem_we;

    logic [11:0]             w_x_end;
    logic [10:0]             w_y_end;
    logic                    w_rd_hit;
    logic [10:0]             w_dx;
    logic [9:0]              w_dy;
    logic [ADDR_W-1:0]       w_rd_addr;
    logic                    w_restart;
    logic                    w_ready;
    logic                    w_push;
    logic                    w_do_write;
    logic                    w_last_write;
    logic [PIXEL_BITS-1:0]   w_fifo_dout;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;

    // One extra bit so a window near the right/bottom edge cannot wrap.
    assign w_x_end  = {1'b0, x_in} + 12'(WIDTH);
    assign w_y_end  = {1'b0, y_in} + 11'(HEIGHT);
    assign w_rd_hit = ({1'b0, hcount_in} >= {1'b0, x_in}) && ({1'b0, hcount_in} < w_x_end) &&
                      ({1'b0, vcount_in} >= {1'b0, y_in}) && ({1'b0, vcount_in} < w_y_end);
    assign w_dx      = hcount_in - x_in;
    assign w_dy      = vcount_in - y_in;
    assign w_rd_addr = ADDR_W'(w_dx) + ADDR_W'(ADDR_W'(w_dy) * ADDR_W'(WIDTH));

    // A restart cycle neither accepts nor writes, so nothing of the old image leaks past the flush.
    assign w_restart    = bus.load_start_in && (r_state != DONE);
    assign w_ready      = (r_state == LOAD) && !w_fifo_full && (r_accept_cnt < CNT_W'(TOTAL)) && !w_restart;
    assign w_push       = bus.wr_valid_in && w_ready;
    assign w_do_write   = !w_rd_hit && (r_state == LOAD) && !w_fifo_empty && !w_restart;
    assign w_last_write = w_do_write && (r_wr_addr == ADDR_W'(TOTAL - 1));

    sprite_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_BITS)
    ) u_fifo (
        .i_clk   (pixel_clk_in),
        .i_rst   (rst_in),
        .i_flush (w_restart),
        .i_push  (w_push),
        .i_data  (bus.wr_data_in),
        .i_pop   (w_do_write),
        .o_data  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.load_start_in) w_state_nxt = LOAD;
            LOAD:    if (bus.load_start_in) w_state_nxt = LOAD;
                     else if (w_last_write) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_wr_addr    <= '0;
            r_accept_cnt <= '0;
            r_hit_pipe   <= '0;
            r_load_done  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_mem_we     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hit_pipe  <= {r_hit_pipe[READ_LATENCY-2:0], w_rd_hit};
            r_load_done <= (r_state == DONE);
            if (w_restart) begin
                r_wr_addr    <= '0;
                r_accept_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_accept_cnt <= r_accept_cnt + 1'b1;
                end
                if (w_do_write) begin
                    r_wr_addr <= w_last_write ? '0 : r_wr_addr + 1'b1;
                end
            end
            if (w_rd_hit) begin
                r_mem_addr <= w_rd_addr;
                r_mem_din  <= '0;
                r_mem_we   <= 1'b0;
            end else if (w_do_write) begin
                r_mem_addr <= r_wr_addr;
                r_mem_din  <= w_fifo_dout;
                r_mem_we   <= 1'b1;
            end else begin
                r_mem_addr <= '0;
                r_mem_din  <= '0;
                r_mem_we   <= 1'b0;
            end
        end
    end

    assign bus.wr_ready_out  = w_ready;
    assign bus.loading_out   = (r_state == LOAD);
    assign bus.load_done_out = r_load_done;
    assign bus.mem_addr_out  = r_mem_addr;
    assign bus.mem_din_out   = r_mem_din;
    assign bus.mem_we_out    = r_mem_we;
    assign in_sprite_out     = r_hit_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_sprite_mem_scheduler.sv
// Scoreboard bench for sprite_mem_scheduler using a reduced 64x4 sprite.
module tb_sprite_mem_scheduler;
    import sprite_pkg::*;

    localparam int TW    = 64;
    localparam int TH    = 4;
    localparam int TOTAL = TW * TH;
    localparam int AW    = $clog2(TOTAL);

    typedef struct packed {
        int addr;
        int data;
    } exp_wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] x;
    logic [9:0]  y;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        in_sprite;

    sprite_mem_scheduler_if #(.PIXEL_BITS(2), .ADDR_W(AW)) bus ();

    sprite_mem_scheduler #(
        .WIDTH      (TW),
        .HEIGHT     (TH),
        .PIXEL_BITS (2),
        .FIFO_DEPTH (16)
    ) dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .x_in          (x),
        .y_in          (y),
        .hcount_in     (hc),
        .vcount_in     (vc),
        .bus           (bus),
        .in_sprite_out (in_sprite)
    );

    always #5 clk = ~clk;

    int      n_cmp = 0;
    int      n_err = 0;
    exp_wr_t q[$];
    int      exp_waddr = 0;
    int      n_push = 0;
    int      writes_since_start = 0;
    int      n_done = 0;
    bit      prev_we_last = 1'b0;
    bit      saw_stall = 1'b0;
    bit [2:0] m_pipe = '0;
    bit      m_prev_hit = 1'b0;
    bit      m_prev_rst = 1'b1;
    int      m_prev_raddr = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_hit(input int h, input int v, input int xs, input int ys);
        return (h >= xs) && (h < xs + TW) && (v >= ys) && (v < ys + TH);
    endfunction

    // Reference window/latency model, advanced on each clock edge from the bench's own inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_pipe     = '0;
            m_prev_hit = 1'b0;
            m_prev_rst = 1'b1;
        end else begin
            m_prev_hit   = model_hit(int'(hc), int'(vc), int'(x), int'(y));
            m_pipe       = {m_pipe[1:0], m_prev_hit};
            m_prev_raddr = (int'(hc) - int'(x)) + (int'(vc) - int'(y)) * TW;
            m_prev_rst   = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_wr_t e;
        if (m_prev_rst) begin
            check_eq("rst_we", int'(bus.mem_we_out), 0);
            check_eq("rst_addr", int'(bus.mem_addr_out), 0);
            check_eq("rst_din", int'(bus.mem_din_out), 0);
            check_eq("rst_in_sprite", int'(in_sprite), 0);
            check_eq("rst_done", int'(bus.load_done_out), 0);
            check_eq("rst_loading", int'(bus.loading_out), 0);
            check_eq("rst_ready", int'(bus.wr_ready_out), 0);
        end else begin
            check_eq("in_sprite_delay", int'(in_sprite), int'(m_pipe[2]));
            if (m_prev_hit) begin
                check_eq("read_no_we", int'(bus.mem_we_out), 0);
                check_eq("read_addr", int'(bus.mem_addr_out), m_prev_raddr);
            end
            if (bus.mem_we_out) begin
                writes_since_start++;
                if (q.size() == 0) begin
                    check_eq("spurious_write", 1, 0);
                end else begin
                    e = q.pop_front();
                    check_eq("write_addr", int'(bus.mem_addr_out), e.addr);
                    check_eq("write_data", int'(bus.mem_din_out), e.data);
                end
            end
            if (bus.load_done_out) begin
                n_done++;
                check_eq("done_after_last_write", int'(prev_we_last), 1);
                check_eq("done_write_count", writes_since_start, TOTAL);
            end
        end
        prev_we_last = bus.mem_we_out && (int'(bus.mem_addr_out) == TOTAL - 1);

        if (rst) begin
            q.delete();
            exp_waddr = 0;
            n_push    = 0;
        end else if (bus.load_start_in) begin
            q.delete();
            exp_waddr          = 0;
            n_push             = 0;
            writes_since_start = 0;
        end else if (bus.wr_valid_in && bus.wr_ready_out) begin
            q.push_back('{addr: exp_waddr, data: int'(bus.wr_data_in)});
            exp_waddr++;
            n_push++;
        end
        if (!rst && bus.loading_out && !bus.wr_ready_out && n_push < TOTAL &&
            model_hit(int'(hc), int'(vc), int'(x), int'(y)))
            saw_stall = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.wr_data_in = 2'($urandom_range(0, 3));
    endtask

    task automatic pulse_start();
        logic v;
        v = bus.wr_valid_in;
        bus.wr_valid_in   = 1'b0;
        bus.load_start_in = 1'b1;
        tick();
        bus.load_start_in = 1'b0;
        bus.wr_valid_in   = v;
    endtask

    task automatic wait_done(input int limit);
        int base;
        base = n_done;
        for (int i = 0; i < limit && n_done == base; i++) tick();
        if (n_done == base) check_eq("done_timeout", 0, 1);
    endtask

    int done_base;
    int hi_cnt;

    initial begin
        x = '0; y = '0; hc = 11'd1500; vc = '0;
        bus.load_start_in = 1'b0;
        bus.wr_valid_in   = 1'b0;
        bus.wr_data_in    = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("post_reset_loading", int'(bus.loading_out), 0);

        // Blanking load
        done_base = n_done;
        pulse_start();
        bus.wr_valid_in = 1'b1;
        wait_done(TOTAL * 3 + 50);
        bus.wr_valid_in = 1'b0;
        repeat (5) tick();
        check_eq("blank_done_count", n_done - done_base, 1);
        check_eq("blank_idle_after", int'(bus.loading_out), 0);

        // Contention with a scanning raster
        x = 11'd10; y = 10'd1; hc = '0; vc = 10'd1;
        done_base = n_done;
        saw_stall = 1'b0;
        pulse_start();
        bus.wr_valid_in = 1'b1;
        for (int i = 0; i < 8000 && n_done == done_base; i++) begin
            tick();
            if (hc == 11'd1649) begin
                hc = '0;
                vc = (vc == 10'd524) ? '0 : vc + 1'b1;
            end else begin
                hc = hc + 1'b1;
            end
        end
        bus.wr_valid_in = 1'b0;
        hc = 11'd1500;
        repeat (5) tick();
        check_eq("contention_done_count", n_done - done_base, 1);
        check_eq("contention_fifo_stall", int'(saw_stall), 1);

        // Read address and in_sprite alignment
        x = '0; y = '0; vc = 10'd2;
        repeat (4) tick();
        hc = 11'd5;
        tick();
        check_eq("align_addr", int'(bus.mem_addr_out), 5 + 2 * TW);
        check_eq("align_we", int'(bus.mem_we_out), 0);
        hc = 11'(TW);
        tick();
        check_eq("align_sprite_early", int'(in_sprite), 0);
        tick();
        check_eq("align_sprite_hit", int'(in_sprite), 1);
        tick();
        check_eq("align_sprite_edge", int'(in_sprite), 0);

        // Restart with buffered pixels
        hc = 11'd1500; vc = '0;
        repeat (3) tick();
        pulse_start();
        bus.wr_valid_in = 1'b1;
        repeat (100) tick();
        hc = 11'd5;
        repeat (10) tick();
        done_base = n_done;
        pulse_start();
        hc = 11'd1500;
        wait_done(TOTAL * 3 + 50);
        bus.wr_valid_in = 1'b0;
        repeat (5) tick();
        check_eq("restart_done_count", n_done - done_base, 1);

        // Reset mid-load with FIFO partly full
        pulse_start();
        bus.wr_valid_in = 1'b1;
        repeat (20) tick();
        hc = 11'd5;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_we", int'(bus.mem_we_out), 0);
        check_eq("midrst_addr", int'(bus.mem_addr_out), 0);
        check_eq("midrst_ready", int'(bus.wr_ready_out), 0);
        check_eq("midrst_loading", int'(bus.loading_out), 0);
        hc = 11'd1500;
        done_base = n_done;
        repeat (20) tick();
        check_eq("midrst_no_done", n_done - done_base, 0);
        pulse_start();
        wait_done(TOTAL * 3 + 50);
        bus.wr_valid_in = 1'b0;
        repeat (5) tick();
        check_eq("after_rst_done_count", n_done - done_base, 1);

        // Window touching the end of the 11-bit column range
        x = 11'd2000; y = '0; vc = '0;
        hi_cnt = 0;
        for (int h = 1990; h <= 2047; h++) begin
            hc = 11'(h);
            tick();
            if (in_sprite) hi_cnt++;
        end
        hc = '0;
        repeat (4) begin
            tick();
            if (in_sprite) hi_cnt++;
        end
        check_eq("edge_window_hits", hi_cnt, 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
